// File: rtl/cav_dl_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : cav_dl_pkg
// Description : Shared types and defaults for the ROM download sequencer.
//               Holds the sequencer state encoding, the default download
//               length and core-reset hold time, and the FIFO entry packing.
// Revision    : 1.0 - initial release
// ============================================================================
package cav_dl_pkg;

    // Sequencer states; explicit width and values keep the encoding stable.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        HOLD  = 3'd3,
        RUN   = 3'd4
    } dl_state_t;

    // Exact byte count of a valid ROM image.
    localparam logic [15:0] EXP_LEN_DEF  = 16'hC000;
    // Cycles the game core is held in reset after the FIFO drains.
    localparam int unsigned HOLD_CYC_DEF = 16;
    // FIFO entry: {rom_addr[15:0], rom_byte[7:0]}.
    localparam int unsigned FIFO_W       = 24;

    function automatic logic [FIFO_W-1:0] dl_pack(input logic [15:0] addr,
                                                  input logic [7:0]  data);
        return {addr, data};
    endfunction

endpackage : cav_dl_pkg
`default_nettype wire

// File: rtl/dl_fifo2.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : dl_fifo2
// Description : Two-entry in-order FIFO decoupling HPS byte strobes from the
//               core ROM write port. Push into a full FIFO and pop from an
//               empty FIFO are ignored, so the occupancy never leaves 0..2.
// Ports       : clk      - clock
//               rst_n    - asynchronous active-low reset (empties the FIFO)
//               i_push   - write i_data this cycle
//               i_data   - entry to write
//               i_pop    - discard the head entry this cycle
//               o_count  - registered occupancy 0..2
//               o_head   - oldest entry (valid when o_count != 0)
// Revision    : 1.0 - initial release
// ============================================================================
module dl_fifo2
    import cav_dl_pkg::*;
#(
    parameter int unsigned WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [1:0]       o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem0;   // head slot
    logic [WIDTH-1:0] r_mem1;   // tail slot when two entries are held
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != 2'd2);
    assign w_pop   = i_pop  && (r_count != 2'd0);
    assign o_count = r_count;
    assign o_head  = r_mem0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_mem0  <= '0;
            r_mem1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem1 <= i_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                // Simultaneous push and pop can only happen with exactly one
                // entry held (push is blocked when full, pop when empty), so
                // the new entry simply replaces the departing head.
                2'b11: begin
                    r_mem0 <= i_data;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : dl_fifo2
`default_nettype wire

// File: rtl/rom_dl_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : rom_dl_sequencer
// Description : Sequences an HPS ROM download into the game core. Bytes are
//               buffered in a 2-entry FIFO and replayed as core ROM writes;
//               the core is held in reset until a complete image has been
//               written, then released after a fixed hold time.
// Ports       : clk_sys        - sole clock
//               reset_n        - asynchronous active-low reset
//               ioctl_download - HPS download window
//               ioctl_wr       - one-cycle HPS byte strobe
//               ioctl_addr     - HPS byte address
//               ioctl_dout     - HPS byte data
//               ioctl_wait     - backpressure to HPS (FIFO full)
//               dn_addr        - core ROM write address
//               dn_data        - core ROM write data
//               dn_wr          - one-cycle core write strobe
//               dn_busy        - core cannot take a write this cycle
//               core_reset     - active-high reset to the game core
//               dl_done        - valid ROM loaded, core released
//               dl_error       - sticky error for the current download
// Revision    : 1.0 - initial release
// ============================================================================
module rom_dl_sequencer
    import cav_dl_pkg::*;
#(
    parameter logic [15:0] EXP_LEN  = EXP_LEN_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dn_addr,
    output logic [7:0]  dn_data,
    output logic        dn_wr,
    input  logic        dn_busy,
    output logic        core_reset,
    output logic        dl_done,
    output logic        dl_error
);

    localparam logic [16:0] c_exp_cnt   = {1'b0, EXP_LEN};
    localparam logic [24:0] c_addr_lim  = {9'd0, EXP_LEN};
    localparam logic [15:0] c_hold_last = 16'(HOLD_CYC - 1);

    dl_state_t          r_state;
    logic               r_dl_q;       // previous ioctl_download for edge detect
    logic [16:0]        r_byte_cnt;   // accepted bytes, saturating
    logic [15:0]        r_hold_cnt;
    logic               r_dl_error;
    logic               r_dl_done;
    logic               r_core_reset;
    logic               r_dn_wr;
    logic [15:0]        r_dn_addr;
    logic [7:0]         r_dn_data;

    logic [1:0]         w_fifo_count;
    logic [FIFO_W-1:0]  w_fifo_head;
    logic               w_dl_rise;
    logic               w_dl_fall;
    logic               w_addr_ok;
    logic               w_accept;
    logic               w_drop;
    logic               w_pop;

    assign w_dl_rise = ioctl_download && !r_dl_q;
    assign w_dl_fall = !ioctl_download && r_dl_q;
    assign w_addr_ok = (ioctl_addr < c_addr_lim);
    // Acceptance looks at the registered occupancy only: a pop in the same
    // cycle does not make room for a strobe that arrives while full.
    assign w_accept  = ioctl_wr && (r_state == LOAD) &&
                       (w_fifo_count != 2'd2) && w_addr_ok;
    assign w_drop    = ioctl_wr && !w_accept;
    assign w_pop     = (w_fifo_count != 2'd0) && !dn_busy;

    assign ioctl_wait = (w_fifo_count == 2'd2);
    assign dn_addr    = r_dn_addr;
    assign dn_data    = r_dn_data;
    assign dn_wr      = r_dn_wr;
    assign core_reset = r_core_reset;
    assign dl_done    = r_dl_done;
    assign dl_error   = r_dl_error;

    dl_fifo2 #(
        .WIDTH   (FIFO_W)
    ) u_fifo (
        .clk     (clk_sys),
        .rst_n   (reset_n),
        .i_push  (w_accept),
        .i_data  (dl_pack(ioctl_addr[15:0], ioctl_dout)),
        .i_pop   (w_pop),
        .o_count (w_fifo_count),
        .o_head  (w_fifo_head)
    );

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_dl_q       <= 1'b0;
            r_byte_cnt   <= '0;
            r_hold_cnt   <= '0;
            r_dl_error   <= 1'b0;
            r_dl_done    <= 1'b0;
            r_core_reset <= 1'b1;
        end else begin
            r_dl_q <= ioctl_download;
            if (w_dl_rise) begin
                // A new download restarts from any state; queued bytes are
                // left in the FIFO and still reach the core.
                r_state      <= LOAD;
                r_byte_cnt   <= '0;
                r_hold_cnt   <= '0;
                r_dl_error   <= 1'b0;
                r_dl_done    <= 1'b0;
                r_core_reset <= 1'b1;
            end else begin
                if (w_accept && (r_byte_cnt != '1)) begin
                    r_byte_cnt <= r_byte_cnt + 17'd1;
                end
                if (w_drop) begin
                    r_dl_error <= 1'b1;
                end
                case (r_state)
                    IDLE: begin
                    end
                    LOAD: begin
                        if (w_dl_fall) begin
                            r_state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (w_fifo_count == 2'd0) begin
                            r_state    <= HOLD;
                            r_hold_cnt <= '0;
                            if (r_byte_cnt != c_exp_cnt) begin
                                r_dl_error <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (r_hold_cnt == c_hold_last) begin
                            // A stray strobe on the final hold cycle still
                            // counts against releasing the core.
                            if (r_dl_error || w_drop) begin
                                r_state <= IDLE;
                            end else begin
                                r_state      <= RUN;
                                r_core_reset <= 1'b0;
                                r_dl_done    <= 1'b1;
                            end
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 16'd1;
                        end
                    end
                    RUN: begin
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Core write port: one strobe per popped entry, payload held otherwise.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dn_wr   <= 1'b0;
            r_dn_addr <= '0;
            r_dn_data <= '0;
        end else begin
            r_dn_wr <= w_pop;
            if (w_pop) begin
                r_dn_addr <= w_fifo_head[23:8];
                r_dn_data <= w_fifo_head[7:0];
            end
        end
    end

endmodule : rom_dl_sequencer
`default_nettype wire

// File: tb/tb_rom_dl_sequencer.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_rom_dl_sequencer
// Description : Self-checking bench for rom_dl_sequencer. Every byte the HPS
//               side expects to reach the core is queued when driven and
//               compared against each dn_wr strobe in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_dl_sequencer;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic        dn_busy;
    logic        core_reset;
    logic        dl_done;
    logic        dl_error;

    int          checks    = 0;
    int          errors    = 0;
    int          wr_pulses = 0;
    logic [23:0] exp_q[$];

    always #5 clk_sys = ~clk_sys;

    rom_dl_sequencer #(
        .EXP_LEN        (16'hC000),
        .HOLD_CYC       (16)
    ) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wr          (dn_wr),
        .dn_busy        (dn_busy),
        .core_reset     (core_reset),
        .dl_done        (dl_done),
        .dl_error       (dl_error)
    );

    // Scoreboard: every core write must match the oldest expected byte.
    always @(negedge clk_sys) begin
        if (dn_wr === 1'b1) begin
            logic [23:0] w_exp;
            wr_pulses++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_dn_wr: got addr=%h data=%h, required no write",
                         dn_addr, dn_data);
            end else begin
                w_exp = exp_q.pop_front();
                if ({dn_addr, dn_data} !== w_exp) begin
                    errors++;
                    $display("FAIL dn_payload: got addr=%h data=%h, required addr=%h data=%h",
                             dn_addr, dn_data, w_exp[23:8], w_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int i);
        logic [15:0] v;
        v = 16'(i);
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // HPS-style write: honours ioctl_wait, then strobes one byte.
    task automatic hps_write(input logic [24:0] a, input logic [7:0] d, input bit expect_acc);
        int guard;
        guard = 0;
        while (ioctl_wait === 1'b1 && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout: ioctl_wait stuck at %b, required 0", ioctl_wait);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        if (expect_acc) exp_q.push_back({a[15:0], d});
        step();
        ioctl_wr = 1'b0;
    endtask

    // Waits (bounded) for dl_error to rise; returns whether it did.
    task automatic wait_error(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (dl_error === 1'b1) seen = 1'b1;
        end
    endtask

    // Runs n cycles and reports whether the core stayed in reset throughout.
    task automatic watch_held(input int n, output bit ok);
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (core_reset !== 1'b1 || dl_done !== 1'b0) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        dn_busy        = 1'b0;
        repeat (3) step();
        checks++;
        if ({core_reset, dl_done, dl_error, dn_wr, ioctl_wait} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got cr/done/err/wr/wait=%b, required 10000",
                     {core_reset, dl_done, dl_error, dn_wr, ioctl_wait});
        end
        checks++;
        if ({dn_addr, dn_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_payload: got %h, required 000000", {dn_addr, dn_data});
        end
        reset_n = 1'b1;
        step();
    endtask

    // One-cycle write latency, payload hold, then a short (bad length) download.
    task automatic test_latency_short();
        bit seen;
        bit ok;
        ioctl_download = 1'b1;
        step();
        checks++;
        if (core_reset !== 1'b1 || dl_done !== 1'b0 || dl_error !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: got cr=%b done=%b err=%b, required 1 0 0",
                     core_reset, dl_done, dl_error);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h0;
        ioctl_dout = 8'hA5;
        exp_q.push_back({16'h0000, 8'hA5});
        step();
        ioctl_wr = 1'b0;
        checks++;
        if (dn_wr !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got dn_wr=%b, required 0", dn_wr);
        end
        step();
        checks++;
        if (dn_wr !== 1'b1 || dn_addr !== 16'h0000 || dn_data !== 8'hA5) begin
            errors++;
            $display("FAIL latency_write: got wr=%b addr=%h data=%h, required 1 0000 a5",
                     dn_wr, dn_addr, dn_data);
        end
        step();
        checks++;
        if (dn_wr !== 1'b0 || dn_addr !== 16'h0000 || dn_data !== 8'hA5) begin
            errors++;
            $display("FAIL payload_hold: got wr=%b addr=%h data=%h, required 0 0000 a5",
                     dn_wr, dn_addr, dn_data);
        end
        for (int i = 1; i < 5; i++) hps_write(25'(i), pat(i), 1'b1);
        ioctl_download = 1'b0;
        wait_error(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL short_error: got dl_error=%b, required 1", dl_error);
        end
        watch_held(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL short_held: core released after bad download, required core_reset=1 dl_done=0");
        end
    endtask

    // Core busy for 5 cycles mid-stream: FIFO fills, wait asserts, order kept.
    task automatic test_backpressure();
        ioctl_download = 1'b1;
        step();
        dn_busy = 1'b1;
        hps_write(25'h100, pat(256), 1'b1);
        hps_write(25'h101, pat(257), 1'b1);
        checks++;
        if (ioctl_wait !== 1'b1 || dl_error !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got wait=%b err=%b, required 1 0", ioctl_wait, dl_error);
        end
        repeat (3) step();
        dn_busy = 1'b0;
        for (int i = 2; i < 8; i++) hps_write(25'(256 + i), pat(256 + i), 1'b1);
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0 || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL bp_drained: got %0d pending wait=%b, required 0 pending wait=0",
                     exp_q.size(), ioctl_wait);
        end
        ioctl_download = 1'b0;
        repeat (30) step();
    endtask

    // Out-of-range address and write-while-full are both dropped with error.
    task automatic test_drops();
        bit quiet;
        ioctl_download = 1'b1;
        step();
        checks++;
        if (dl_error !== 1'b0) begin
            errors++;
            $display("FAIL drop_clear: got dl_error=%b, required 0", dl_error);
        end
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h000C000;
        ioctl_dout = 8'h77;
        step();
        ioctl_wr = 1'b0;
        checks++;
        if (dl_error !== 1'b1) begin
            errors++;
            $display("FAIL drop_addr_err: got dl_error=%b, required 1", dl_error);
        end
        quiet = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (dn_wr !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL drop_addr_wr: got dn_wr for dropped byte, required none");
        end
        ioctl_download = 1'b0;
        repeat (30) step();

        ioctl_download = 1'b1;
        step();
        dn_busy = 1'b1;
        hps_write(25'h10, 8'h11, 1'b1);
        hps_write(25'h11, 8'h22, 1'b1);
        checks++;
        if (dl_error !== 1'b0 || ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL full_pre: got err=%b wait=%b, required 0 1", dl_error, ioctl_wait);
        end
        // Strobe while full in the very cycle the core frees up.
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'h12;
        ioctl_dout = 8'h33;
        dn_busy    = 1'b0;
        step();
        ioctl_wr = 1'b0;
        checks++;
        if (dl_error !== 1'b1) begin
            errors++;
            $display("FAIL full_drop_err: got dl_error=%b, required 1", dl_error);
        end
        repeat (4) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_drop_order: got %0d pending, required 0", exp_q.size());
        end
        ioctl_download = 1'b0;
        repeat (30) step();
    endtask

    // Reset with two entries queued: outputs reset at once, queue discarded.
    task automatic test_reset_mid();
        bit ok;
        ioctl_download = 1'b1;
        step();
        dn_busy = 1'b1;
        hps_write(25'h20, 8'hC1, 1'b0);
        hps_write(25'h21, 8'hC2, 1'b0);
        checks++;
        if (ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL rmid_full: got wait=%b, required 1", ioctl_wait);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({core_reset, dl_done, dl_error, dn_wr, ioctl_wait} !== 5'b10000 ||
            {dn_addr, dn_data} !== 24'h0) begin
            errors++;
            $display("FAIL rmid_async: got cr/done/err/wr/wait=%b payload=%h, required 10000 000000",
                     {core_reset, dl_done, dl_error, dn_wr, ioctl_wait}, {dn_addr, dn_data});
        end
        dn_busy        = 1'b0;
        ioctl_download = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
        watch_held(8, ok);
        checks++;
        if (!ok || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL rmid_idle: core released or wait=%b after reset, required held and wait=0",
                     ioctl_wait);
        end
    endtask

    // Full 0xC000-byte download back to back: one DRAIN cycle, 16 HOLD cycles.
    task automatic test_full_download();
        int n;
        ioctl_download = 1'b1;
        step();
        wr_pulses = 0;
        for (int i = 0; i < 32'hC000; i++) hps_write(25'(i), pat(i), 1'b1);
        ioctl_download = 1'b0;
        step();
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (i == 1) begin
                checks++;
                if (dl_error !== 1'b0) begin
                    errors++;
                    $display("FAIL full_drain_err: got dl_error=%b, required 0", dl_error);
                end
            end
            if (core_reset === 1'b0) n = i;
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL full_release: got release after %0d cycles, required 17", n);
        end
        step();
        checks++;
        if (dl_done !== 1'b1 || dl_error !== 1'b0 || core_reset !== 1'b0) begin
            errors++;
            $display("FAIL full_status: got done=%b err=%b cr=%b, required 1 0 0",
                     dl_done, dl_error, core_reset);
        end
        checks++;
        if (wr_pulses != 32'hC000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_count: got %0d writes %0d pending, required 49152 and 0",
                     wr_pulses, exp_q.size());
        end
    endtask

    // Re-download from RUN: core back in reset, byte counter starts over.
    task automatic test_rerun();
        bit seen;
        bit ok;
        ioctl_download = 1'b1;
        step();
        checks++;
        if (dl_done !== 1'b0 || core_reset !== 1'b1) begin
            errors++;
            $display("FAIL rerun_entry: got done=%b cr=%b, required 0 1", dl_done, core_reset);
        end
        ioctl_download = 1'b0;
        wait_error(seen);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rerun_count_clear: got dl_error=%b for empty download, required 1",
                     dl_error);
        end
        watch_held(40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rerun_held: core released after empty download, required held");
        end
    endtask

    initial begin
        test_reset();
        test_latency_short();
        test_backpressure();
        test_drops();
        test_reset_mid();
        test_full_download();
        test_rerun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rom_dl_sequencer
`default_nettype wire
